// File: rtl/seq_coef_mult_pkg.sv
// Shared definitions for the coefficient-sequencing multiplier: state encoding
// and the default coefficient table (x1, x3, x7, x8).
package seq_coef_mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [15:0] COEFS_DEFAULT = 16'h8731;

endpackage

// File: rtl/seq_coef_mult_coef_sel.sv
// Combinational NCOEF:1 coefficient mux over the packed coefficient table.
// Indices beyond NCOEF-1 select zero.
module seq_coef_mult_coef_sel
  import seq_coef_mult_pkg::*;
#(
  parameter int CW    = 4,
  parameter int NCOEF = 4,
  parameter int IW    = 2,
  parameter logic [NCOEF*CW-1:0] COEFS = COEFS_DEFAULT
) (
  input  logic [IW-1:0] idx,
  output logic [CW-1:0] coef
);

  always_comb begin
    coef = '0;
    for (int i = 0; i < NCOEF; i++) begin
      if (idx == IW'(i)) coef = COEFS[i*CW +: CW];
    end
  end

endmodule

// File: rtl/seq_coef_mult.sv
// Captures one sample per handshake and emits sample x COEF[i] for i = 0..NCOEF-1
// as registered output beats, with full backpressure and a synchronous flush.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no sample held, out_valid low, ready for a new sample
//   EMIT    | presenting beat idx of the held sample, waiting on out_ready
module seq_coef_mult
  import seq_coef_mult_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 4,
  parameter int NCOEF = 4,
  parameter logic [NCOEF*CW-1:0] COEFS = COEFS_DEFAULT,
  localparam int OW = DW + CW,
  localparam int IW = $clog2(NCOEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  input  logic          out_ready
);

  state_e        state_q, state_d;
  logic [DW-1:0] sample_q, sample_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [OW-1:0] data_q, data_d;
  logic          last_q, last_d;

  logic          hs;
  logic          accept;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] mul_sample;
  logic [CW-1:0] coef;
  logic [OW-1:0] product;

  assign out_valid = (state_q == ST_EMIT);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

  // The next product is computed one beat ahead so every beat leaves a register.
  always_comb begin
    hs         = out_valid && out_ready;
    in_ready   = !rst && !flush && (state_q == ST_IDLE || (hs && last_q));
    accept     = in_valid && in_ready;
    sel_idx    = accept ? '0 : idx_q + IW'(1);
    mul_sample = accept ? in_data : sample_q;
  end

  seq_coef_mult_coef_sel #(
    .CW    (CW),
    .NCOEF (NCOEF),
    .IW    (IW),
    .COEFS (COEFS)
  ) u_coef_sel (
    .idx  (sel_idx),
    .coef (coef)
  );

  assign product = OW'(mul_sample) * OW'(coef);

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    data_d   = data_q;
    last_d   = last_q;
    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      last_d  = 1'b0;
    end else if (accept) begin
      state_d  = ST_EMIT;
      sample_d = in_data;
      idx_d    = '0;
      data_d   = product;
      last_d   = 1'b0;
    end else if (hs) begin
      if (last_q) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
      end else begin
        idx_d  = sel_idx;
        data_d = product;
        last_d = (sel_idx == IW'(NCOEF - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_seq_coef_mult.sv
// Scoreboard bench for seq_coef_mult: accepted samples expand into expected beats,
// a negedge monitor pops and compares them; plus a small-parameter variant.
module tb_seq_coef_mult;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_last, out_ready;
  logic [7:0]  in_data;
  logic [11:0] out_data;
  logic [1:0]  out_idx;

  logic        v_rst, v_flush, v_in_valid, v_in_ready, v_out_valid, v_out_last, v_out_ready;
  logic [3:0]  v_in_data;
  logic [6:0]  v_out_data;
  logic [1:0]  v_out_idx;

  always #5 clk = ~clk;

  seq_coef_mult u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_ready(out_ready)
  );

  seq_coef_mult #(.DW(4), .CW(3), .NCOEF(3), .COEFS(9'o521)) u_var (
    .clk(clk), .rst(v_rst), .flush(v_flush), .in_valid(v_in_valid), .in_data(v_in_data),
    .in_ready(v_in_ready), .out_valid(v_out_valid), .out_data(v_out_data), .out_idx(v_out_idx),
    .out_last(v_out_last), .out_ready(v_out_ready)
  );

  typedef struct packed {
    int data;
    int idx;
    bit last;
  } beat_t;

  beat_t sb[$];
  int    coef_tbl[4] = '{1, 3, 7, 8};
  int    n_checks = 0;
  int    n_fail = 0;
  bit    rnd_en;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  // Monitor: in_ready/out_valid follow from the pending beat list; beats pop on handshake.
  bit    prev_stall = 1'b0;
  int    prev_data, prev_idx, prev_last;
  always @(negedge clk) begin
    bit    exp_rdy;
    beat_t b;
    exp_rdy = !rst && !flush && (sb.size() == 0 || (sb.size() == 1 && out_ready));
    check("in_ready", int'(in_ready), int'(exp_rdy));
    check("out_valid", int'(out_valid), int'(sb.size() != 0));
    if (prev_stall) begin
      check("hold_data", int'(out_data), prev_data);
      check("hold_idx", int'(out_idx), prev_idx);
      check("hold_last", int'(out_last), prev_last);
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      b = sb.pop_front();
      check("out_data", int'(out_data), b.data);
      check("out_idx", int'(out_idx), b.idx);
      check("out_last", int'(out_last), int'(b.last));
    end
    prev_stall = out_valid && !out_ready && !rst && !flush;
    prev_data  = int'(out_data);
    prev_idx   = int'(out_idx);
    prev_last  = int'(out_last);
    if (rst || flush) sb.delete();
  end

  task automatic send(input logic [7:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
          sb.push_back('{data: int'(d) * coef_tbl[i], idx: i, last: (i == 3)});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) timeout("send");
  endtask

  task automatic wait_idx(input int k);
    bit ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && int'(out_idx) == k) ok = 1'b1;
    end
    if (!ok) timeout("wait_idx");
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) ok = 1'b1;
    end
    if (!ok) timeout("drain");
  endtask

  initial begin
    int v_exp[3] = '{15, 30, 75};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    v_rst = 1'b1; v_flush = 1'b0; v_in_valid = 1'b0; v_in_data = '0; v_out_ready = 1'b1;
    rnd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", int'(out_data), 0);
    check("rst_idx", int'(out_idx), 0);
    check("rst_last", int'(out_last), 0);
    rst = 1'b0;

    // basic and back-to-back
    send(8'hFF);
    send(8'h05);
    send(8'h0A);
    drain();

    // backpressure on beat 1
    send(8'h02);
    wait_idx(1);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // flush on beat 2, with the next sample offered during the flush cycle
    send(8'h10);
    wait_idx(2);
    flush = 1'b1;
    fork
      begin
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_valid", int'(out_valid), 0);
        check("flush_keep_data", int'(out_data), 112);
        check("flush_idx", int'(out_idx), 0);
      end
      send(8'h01);
    join
    drain();

    // reset on beat 1, with a sample offered during reset
    send(8'h03);
    wait_idx(1);
    rst = 1'b1;
    fork
      begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_idx", int'(out_idx), 0);
        check("mid_rst_last", int'(out_last), 0);
      end
      send(8'h09);
    join
    drain();

    // randomized samples, gaps and backpressure
    rnd_en = 1'b1;
    fork
      while (rnd_en) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom));
        end
        rnd_en = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain();

    // parameter variant: x1, x2, x5 with a 4-bit sample
    @(posedge clk);
    #1;
    v_rst = 1'b0;
    v_in_valid = 1'b1;
    v_in_data = 4'hF;
    @(negedge clk);
    check("var_in_ready", int'(v_in_ready), 1);
    @(posedge clk);
    #1;
    v_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("var_valid", int'(v_out_valid), 1);
      check("var_data", int'(v_out_data), v_exp[i]);
      check("var_idx", int'(v_out_idx), i);
      check("var_last", int'(v_out_last), int'(i == 2));
    end
    @(negedge clk);
    check("var_idle", int'(v_out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_coef_mult.md
Name: seq_coef_mult

Overview:
- Parametrised successor to the fixed 4-phase ×1/×3/×7/×8 sequencer.
- Captures one DW-bit sample through a valid/ready handshake.
- Emits NCOEF products, one per accepted output beat: sample × COEF[0], sample × COEF[1], …, sample × COEF[NCOEF-1].
- Sits between a sample source and downstream arithmetic. Full output backpressure and a synchronous flush, neither of which the fixed sequencer has.

Parameters:
- DW, 8: input sample width.
- CW, 4: width of each coefficient (unsigned).
- NCOEF, 4: number of coefficients/output beats per sample (2..16).
- COEFS, 16'h8731: packed coefficient table, NCOEF×CW bits; COEF[i] = COEFS[i*CW +: CW]. The default gives ×1, ×3, ×7, ×8.
- OW, DW+CW: output width (derived localparam, not overridable).
- IW, clog2(NCOEF): beat index width (derived).

Ports:
- clk, input, 1: clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous abort of current sample.
- in_valid, input, 1: sample valid.
- in_data, input, DW: sample.
- in_ready, output, 1: block can accept a sample this cycle.
- out_valid, output, 1: product valid.
- out_data, output, OW: product.
- out_idx, output, IW: coefficient index of current product.
- out_last, output, 1: current product uses COEF[NCOEF-1].
- out_ready, input, 1: downstream accepts product.

Behaviour:
- Reset: one synchronous reset, active-high.
  - While rst=1 at a clk edge: state←IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, held sample=0.
  - in_ready=0 while rst=1.
  - rst overrides flush and all handshakes. Reset mid-EMIT discards the sample with no further beats.
- States: IDLE, EMIT.
- in_ready (combinational) = !rst && !flush && (state==IDLE || (out_valid && out_ready && out_last)).
- Accept: in_valid && in_ready at edge T.
  - Sample is registered.
  - state←EMIT, out_valid=1 from T+1, out_idx=0, out_data = sample×COEF[0].
  - Latency: 1 cycle from accept to first product.
- Output beat:
  - Handshake = out_valid && out_ready.
  - On handshake with idx<NCOEF-1: idx←idx+1, out_data←sample×COEF[idx+1].
  - On handshake of the last beat: if a new sample is accepted in the same cycle, go to idx 0 of the new sample with no bubble. Otherwise state←IDLE and out_valid←0.
  - Throughput: one sample per NCOEF cycles when out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last are held stable. No beat is dropped or repeated.
- out_last = out_valid && (out_idx == NCOEF-1), registered alongside out_data.
- Arithmetic:
  - Unsigned, full precision, zero-extended to OW. No truncation or overflow.
  - Products are registered outputs, not combinational.
- flush (rst=0):
  - At the edge: state←IDLE, out_valid←0, idx←0. out_data keeps its last value.
  - in_ready=0 during the flush cycle, so no sample is accepted.
  - flush in IDLE has no effect beyond masking in_ready.
- in_valid while in_ready=0 is ignored. The source must hold it.
- out_idx wraps only via the last-beat rule; it never exceeds NCOEF-1.

Decomposition:
- Shared package/header (seq_coef_mult_pkg): state encoding localparams (ST_IDLE=1'b0, ST_EMIT=1'b1) and the default coefficient table constant 16'h8731.
- Sub-module coef_sel: combinational NCOEF:1 coefficient mux, input idx, output CW-bit COEF[idx]. The product multiply and all registers stay in the top.

Test Plan:
- Basic sequence:
  - Stimulus: rst high 2 cycles, then in_data=8'hFF, in_valid=1, out_ready=1.
  - Response: in_ready=1 in the first post-reset cycle. Outputs 255, 765, 1785, 2040 with idx 0..3 on consecutive cycles; out_last only on 2040.
- Back-to-back samples:
  - Stimulus: 8'h05 then 8'h0A, in_valid held high, out_ready=1.
  - Response: 5, 15, 35, 40, 10, 30, 70, 80 with no gap. in_ready high exactly on the cycles showing 40 and 80.
- Backpressure:
  - Stimulus: sample 8'h02; drop out_ready for 3 cycles while beat idx1 is showing.
  - Response: out_data=6 and out_idx=1 stable for 3 cycles, then 14, 16. in_ready stays 0 until the last beat's handshake.
- Flush mid-operation:
  - Stimulus: sample 8'h10; assert flush for 1 cycle while idx2 (112) is showing.
  - Response: out_valid=0 next cycle, in_ready=0 during flush and 1 after. The next sample 8'h01 yields 1, 3, 7, 8.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle during idx1, with in_valid=1 in the same cycle.
  - Response: all outputs zero after the edge, sample not accepted, in_ready=0 during rst.
- Parameter variant:
  - Stimulus: DW=4, CW=3, NCOEF=3, COEFS=9'o521 (×1, ×2, ×5); sample 4'hF, out_ready=1.
  - Response: 15, 30, 75 (OW=7), out_last on 75, out_idx 0, 1, 2.
